// File: rtl/antirrebote_pkg.sv
// Shared defaults and width helper for the multi-channel debouncer.
package antirrebote_pkg;

  localparam int unsigned DEF_DEB_CYCLES  = 240000;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int unsigned f_clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One debounce channel: synchroniser, stability counter, edge pulses and
// optional long-press detector.
module antirrebote_canal
  import antirrebote_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LONG_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  localparam int unsigned CNT_W = f_clog2_min1(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_cand;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_level_dly;
  logic                   r_rise;
  logic                   r_fall;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync      <= '0;
      r_cand      <= 1'b0;
      r_cnt       <= '0;
      r_level     <= 1'b0;
      r_level_dly <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // Counter saturates at CNT_MAX; the level is accepted while saturated.
      if (w_sync != r_cand) begin
        r_cand <= w_sync;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_level <= r_cand;
      end
      r_level_dly <= r_level;
      r_rise      <= r_level & ~r_level_dly;
      r_fall      <= ~r_level & r_level_dly;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

  if (LONG_CYCLES > 0) begin : g_long
    localparam int unsigned LW = f_clog2_min1(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES);

    logic [LW-1:0] r_long_cnt;
    logic          r_long;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_long_cnt <= '0;
        r_long     <= 1'b0;
      end else begin
        if (!r_level) begin
          r_long_cnt <= '0;
        end else if (r_long_cnt < LMAX) begin
          r_long_cnt <= r_long_cnt + LW'(1);
        end
        // Fires once: the count passes LMAX-1 only once per press.
        r_long <= r_level && (r_long_cnt == (LMAX - LW'(1)));
      end
    end

    assign o_long = r_long;
  end else begin : g_no_long
    assign o_long = 1'b0;
  end

endmodule

// File: rtl/antirrebote_multi.sv
// N_CH independent debounce channels; the top only replicates the channel.
module antirrebote_multi
  import antirrebote_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned LONG_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] senal_entrada,
  output logic [N_CH-1:0] salida_limpia,
  output logic [N_CH-1:0] flanco_subida,
  output logic [N_CH-1:0] flanco_bajada,
  output logic [N_CH-1:0] pulsacion_larga
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    antirrebote_canal #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_canal (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_raw  (senal_entrada[i]),
      .o_level(salida_limpia[i]),
      .o_rise (flanco_subida[i]),
      .o_fall (flanco_bajada[i]),
      .o_long (pulsacion_larga[i])
    );
  end

endmodule

// File: tb/tb_antirrebote_multi.sv
// Scoreboard bench: stimulus queues expected pulse events, a monitor checks them.
module tb_antirrebote_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] senal_entrada;
  logic [3:0] salida_limpia;
  logic [3:0] flanco_subida;
  logic [3:0] flanco_bajada;
  logic [3:0] pulsacion_larga;

  antirrebote_multi #(
    .N_CH       (4),
    .DEB_CYCLES (4),
    .SYNC_STAGES(2),
    .LONG_CYCLES(10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .senal_entrada  (senal_entrada),
    .salida_limpia  (salida_limpia),
    .flanco_subida  (flanco_subida),
    .flanco_bajada  (flanco_bajada),
    .pulsacion_larga(pulsacion_larga)
  );

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] l;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Any pulse must match the head of the queue; a due entry with no pulse is a miss.
  initial forever begin
    @(posedge clk);
    #1;
    if ((flanco_subida | flanco_bajada | pulsacion_larga) != 4'b0000) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d got r=%b f=%b l=%b required none",
                 cyc, flanco_subida, flanco_bajada, pulsacion_larga);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.r !== flanco_subida || e.f !== flanco_bajada ||
            e.l !== pulsacion_larga) begin
          n_err++;
          $display("FAIL pulse got cyc=%0d r=%b f=%b l=%b required cyc=%0d r=%b f=%b l=%b",
                   cyc, flanco_subida, flanco_bajada, pulsacion_larga,
                   e.cyc, e.r, e.f, e.l);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      ev_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_pulse cyc=%0d got none required cyc=%0d r=%b f=%b l=%b",
               cyc, e.cyc, e.r, e.f, e.l);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic push(input int c, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] l);
    ev_t e;
    e.cyc = c;
    e.r   = r;
    e.f   = f;
    e.l   = l;
    q.push_back(e);
  endtask

  // Drive on the falling edge; the next rising edge is cyc+1.
  task automatic set_in(input logic [3:0] v);
    @(negedge clk);
    senal_entrada = v;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_lvl(input string name, input logic [3:0] exp);
    n_vec++;
    if (salida_limpia !== exp) begin
      n_err++;
      $display("FAIL %s salida_limpia got %b required %b", name, salida_limpia, exp);
    end
  endtask

  task automatic check_pulses_zero(input string name);
    n_vec++;
    if ((flanco_subida | flanco_bajada | pulsacion_larga) !== 4'b0000) begin
      n_err++;
      $display("FAIL %s pulses got r=%b f=%b l=%b required 0000", name,
               flanco_subida, flanco_bajada, pulsacion_larga);
    end
  endtask

  initial begin
    int e;
    int r;
    rst_n         = 1'b0;
    senal_entrada = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_lvl("reset_level", 4'b0000);
    check_pulses_zero("reset_pulses");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ch0 held high: level at E+6, rise pulse at E+7, long press at E+16.
    set_in(4'b0001);
    e = cyc + 1;
    push(e + 7, 4'b0001, 4'b0000, 4'b0000);
    push(e + 16, 4'b0000, 4'b0000, 4'b0001);
    wait_until(e + 5);
    check_lvl("ch0_before_latency", 4'b0000);
    wait_until(e + 6);
    check_lvl("ch0_at_latency", 4'b0001);
    wait_until(e + 20);
    set_in(4'b0000);
    r = cyc + 1;
    push(r + 7, 4'b0000, 4'b0001, 4'b0000);
    wait_until(r + 10);
    check_lvl("ch0_released", 4'b0000);

    // ch1 glitch of 3 cycles is rejected.
    set_in(4'b0010);
    set_in(4'b0010);
    set_in(4'b0010);
    set_in(4'b0000);
    e = cyc + 1;
    wait_until(e + 15);
    check_lvl("ch1_glitch", 4'b0000);

    // ch2 bounces then settles high; timing counts from the last transition.
    set_in(4'b0100);
    set_in(4'b0000);
    set_in(4'b0100);
    set_in(4'b0000);
    set_in(4'b0100);
    e = cyc + 1;
    push(e + 7, 4'b0100, 4'b0000, 4'b0000);
    push(e + 16, 4'b0000, 4'b0000, 4'b0100);
    wait_until(e + 5);
    check_lvl("ch2_before_latency", 4'b0000);
    wait_until(e + 6);
    check_lvl("ch2_at_latency", 4'b0100);
    wait_until(e + 20);
    set_in(4'b0000);
    r = cyc + 1;
    push(r + 7, 4'b0000, 4'b0100, 4'b0000);
    wait_until(r + 10);

    // ch3 held 30 cycles: one long press, then one fall.
    set_in(4'b1000);
    e = cyc + 1;
    push(e + 7, 4'b1000, 4'b0000, 4'b0000);
    push(e + 16, 4'b0000, 4'b0000, 4'b1000);
    wait_until(e + 29);
    check_lvl("ch3_held", 4'b1000);
    set_in(4'b0000);
    r = cyc + 1;
    push(r + 7, 4'b0000, 4'b1000, 4'b0000);
    wait_until(r + 10);

    // ch3 short press: released before the long count completes, no long pulse.
    set_in(4'b1000);
    e = cyc + 1;
    push(e + 7, 4'b1000, 4'b0000, 4'b0000);
    wait_until(e + 7);
    set_in(4'b0000);
    push(e + 15, 4'b0000, 4'b1000, 4'b0000);
    wait_until(e + 25);
    check_lvl("ch3_short_released", 4'b0000);

    // All channels toggled together.
    set_in(4'b1111);
    e = cyc + 1;
    push(e + 7, 4'b1111, 4'b0000, 4'b0000);
    push(e + 16, 4'b0000, 4'b0000, 4'b1111);
    wait_until(e + 6);
    check_lvl("all_at_latency", 4'b1111);
    wait_until(e + 20);
    set_in(4'b0000);
    r = cyc + 1;
    push(r + 7, 4'b0000, 4'b1111, 4'b0000);
    wait_until(r + 10);

    // Reset mid-debounce on ch0 with ch1 already accepted high.
    set_in(4'b0010);
    e = cyc + 1;
    push(e + 7, 4'b0010, 4'b0000, 4'b0000);
    wait_until(e + 8);
    set_in(4'b0011);
    e = cyc + 1;
    wait_until(e + 4);
    check_lvl("pre_reset", 4'b0010);
    rst_n = 1'b0;
    #1;
    check_lvl("reset_mid_level", 4'b0000);
    check_pulses_zero("reset_mid_pulses");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = cyc + 1;
    push(e + 7, 4'b0011, 4'b0000, 4'b0000);
    push(e + 16, 4'b0000, 4'b0000, 4'b0011);
    wait_until(e + 5);
    check_lvl("post_reset_before", 4'b0000);
    wait_until(e + 6);
    check_lvl("post_reset_latency", 4'b0011);
    wait_until(e + 20);
    set_in(4'b0000);
    r = cyc + 1;
    push(r + 7, 4'b0000, 4'b0011, 4'b0000);
    wait_until(r + 12);

    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained got %0d pending required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
